// File: rtl/wc_pkg.sv
// Shared definitions for the wc_clock_gen waveform clock generator.
// Holds the channel state encoding, default sizes and the slice-packing macro.
`ifndef WC_PKG_SV
`define WC_PKG_SV

// Selects channel k's field out of a packed per-channel vector.
`define WC_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package wc_pkg;

   typedef enum logic {
      WC_IDLE = 1'b0,
      WC_RUN  = 1'b1
   } wc_state_e;

   localparam int unsigned WC_NUM_CH    = 2;
   localparam int unsigned WC_PSC_WIDTH = 16;

endpackage

`endif

// File: rtl/wc_channel.sv
// One waveform clock channel: IDLE/RUN FSM, period counter and shadowed prescaler.
// Start phase is honoured only when WC_PHASE_EN is defined; otherwise every start loads 0.
module wc_channel
   import wc_pkg::*;
#(
   parameter int unsigned PSC_WIDTH = WC_PSC_WIDTH
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   input  logic                 en_i,
   input  logic                 sync_i,
   input  logic [PSC_WIDTH-1:0] psc_i,
   input  logic [PSC_WIDTH-1:0] phase_i,
   output logic                 clk_p_o,
   output logic                 run_o
);

   wc_state_e            state_q, state_d;
   logic [PSC_WIDTH-1:0] cnt_q, cnt_d;
   logic [PSC_WIDTH-1:0] psc_q, psc_d;
   logic                 out_q, out_d;
   logic [PSC_WIDTH-1:0] last_act;
   logic [PSC_WIDTH-1:0] start_cnt;

   // Prescalers 0 and 1 both mean a period of one cycle.
   function automatic logic [PSC_WIDTH-1:0] last_of(input logic [PSC_WIDTH-1:0] psc);
      return (psc == '0) ? '0 : psc - PSC_WIDTH'(1);
   endfunction

   assign last_act = last_of(psc_q);

`ifdef WC_PHASE_EN
   logic [PSC_WIDTH-1:0] last_new;

   assign last_new  = last_of(psc_i);
   assign start_cnt = (phase_i > last_new) ? last_new : phase_i;
`else
   logic unused_phase;

   assign unused_phase = ^phase_i;
   assign start_cnt    = '0;
`endif

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q <= WC_IDLE;
         cnt_q   <= '0;
         psc_q   <= '0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         psc_q   <= psc_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      psc_d   = psc_q;
      out_d   = 1'b0;
      unique case (state_q)
         WC_IDLE: begin
            if (en_i) begin
               state_d = WC_RUN;
               psc_d   = psc_i;
               cnt_d   = start_cnt;
            end
         end
         WC_RUN: begin
            // Disable wins over sync, and sync wins over a coincident terminal count.
            if (!en_i) begin
               state_d = WC_IDLE;
               cnt_d   = '0;
            end else if (sync_i) begin
               psc_d = psc_i;
               cnt_d = start_cnt;
            end else if (cnt_q == last_act) begin
               out_d = 1'b1;
               cnt_d = '0;
               psc_d = psc_i;
            end else begin
               cnt_d = cnt_q + PSC_WIDTH'(1);
            end
         end
         default: begin
            state_d = WC_IDLE;
         end
      endcase
   end

   assign clk_p_o = out_q;
   assign run_o   = (state_q == WC_RUN);

endmodule

// File: rtl/wc_clock_gen.sv
// Multi-channel waveform clock generator: NUM_CH independent wc_channel instances
// sharing one sync input. Optional start-phase support via WC_PHASE_EN.
module wc_clock_gen
   import wc_pkg::*;
#(
   parameter int unsigned NUM_CH    = WC_NUM_CH,
   parameter int unsigned PSC_WIDTH = WC_PSC_WIDTH
) (
   input  logic                        sys_clk_i,
   input  logic                        sys_rst_i,
   input  logic [NUM_CH-1:0]           wc_en_i,
   input  logic [NUM_CH*PSC_WIDTH-1:0] wc_psc_i,
   input  logic [NUM_CH*PSC_WIDTH-1:0] wc_phase_i,
   input  logic                        wc_sync_i,
   output logic [NUM_CH-1:0]           wc_clk_p_o,
   output logic [NUM_CH-1:0]           wc_run_o
);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      wc_channel #(
         .PSC_WIDTH(PSC_WIDTH)
      ) u_ch (
         .sys_clk_i(sys_clk_i),
         .sys_rst_i(sys_rst_i),
         .en_i     (wc_en_i[k]),
         .sync_i   (wc_sync_i),
         .psc_i    (`WC_SLICE(wc_psc_i, k, PSC_WIDTH)),
         .phase_i  (`WC_SLICE(wc_phase_i, k, PSC_WIDTH)),
         .clk_p_o  (wc_clk_p_o[k]),
         .run_o    (wc_run_o[k])
      );
   end

endmodule

// File: tb/tb_wc_clock_gen.sv
// Self-checking bench for wc_clock_gen: an event-time model predicts every pulse,
// plus directed literal checks of the key timing cases.
module tb_wc_clock_gen;

   localparam int unsigned NUM_CH    = 2;
   localparam int unsigned PSC_WIDTH = 16;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NUM_CH-1:0]           en;
   logic [NUM_CH*PSC_WIDTH-1:0] psc;
   logic [NUM_CH*PSC_WIDTH-1:0] phase;
   logic                        sync;
   logic [NUM_CH-1:0]           clk_p;
   logic [NUM_CH-1:0]           run;

   int errors = 0;
   int checks = 0;

   wc_clock_gen #(
      .NUM_CH   (NUM_CH),
      .PSC_WIDTH(PSC_WIDTH)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .wc_en_i   (en),
      .wc_psc_i  (psc),
      .wc_phase_i(phase),
      .wc_sync_i (sync),
      .wc_clk_p_o(clk_p),
      .wc_run_o  (run)
   );

   always #5 clk = ~clk;

   // Model: each running channel remembers the absolute edge of its next pulse.
   int edge_n = 0;
   bit m_run [NUM_CH];
   bit m_out [NUM_CH];
   int m_next[NUM_CH];

   function automatic int period_of(input int k);
      int p;
      p = int'(psc[k*PSC_WIDTH +: PSC_WIDTH]);
      return (p == 0) ? 1 : p;
   endfunction

   function automatic int offset_of(input int k);
`ifdef WC_PHASE_EN
      int ph;
      ph = int'(phase[k*PSC_WIDTH +: PSC_WIDTH]);
      return (ph > period_of(k) - 1) ? period_of(k) - 1 : ph;
`else
      return 0 * k;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_n <= 0;
         for (int k = 0; k < NUM_CH; k++) begin
            m_run[k]  <= 1'b0;
            m_out[k]  <= 1'b0;
            m_next[k] <= 0;
         end
      end else begin
         edge_n <= edge_n + 1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (!en[k]) begin
               m_run[k] <= 1'b0;
               m_out[k] <= 1'b0;
            end else if (!m_run[k] || sync) begin
               m_run[k]  <= 1'b1;
               m_out[k]  <= 1'b0;
               m_next[k] <= edge_n + 1 + period_of(k) - offset_of(k);
            end else if (edge_n + 1 == m_next[k]) begin
               m_out[k]  <= 1'b1;
               m_next[k] <= edge_n + 1 + period_of(k);
            end else begin
               m_out[k] <= 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            check($sformatf("model_clk_p[%0d]", k), clk_p[k], m_out[k]);
            check($sformatf("model_run[%0d]", k), run[k], m_run[k]);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ch(input int k, input int p, input int ph);
      psc[k*PSC_WIDTH +: PSC_WIDTH]   = PSC_WIDTH'(p);
      phase[k*PSC_WIDTH +: PSC_WIDTH] = PSC_WIDTH'(ph);
   endtask

`ifdef WC_PHASE_EN
   localparam bit PhaseOn = 1'b1;
`else
   localparam bit PhaseOn = 1'b0;
`endif

   initial begin
      rst   = 1'b1;
      en    = '0;
      psc   = '0;
      phase = '0;
      sync  = 1'b0;
      step(2);
      check("reset_clk_p", clk_p[0], 1'b0);
      check("reset_run", run[0], 1'b0);
      rst = 1'b0;

      // Prescaler 4, phase 0: pulses after E4, E8; then async reset mid-pulse.
      set_ch(0, 4, 0);
      en[0] = 1'b1;
      step(1);
      check("t1_run_after_e0", run[0], 1'b1);
      check("t1_no_pulse_e0", clk_p[0], 1'b0);
      step(3);
      check("t1_no_pulse_e3", clk_p[0], 1'b0);
      step(1);
      check("t1_pulse_e4", clk_p[0], 1'b1);
      step(1);
      check("t1_low_e5", clk_p[0], 1'b0);
      step(3);
      check("t1_pulse_e8", clk_p[0], 1'b1);
      #2 rst = 1'b1;
      #1;
      check("t1_async_reset_clk_p", clk_p[0], 1'b0);
      check("t1_async_reset_run", run[0], 1'b0);
      step(1);
      en[0] = 1'b0;
      rst   = 1'b0;
      step(1);

      // Prescaler 5, rewritten to 2 at count 1: pulse at E5, then E7, E9.
      set_ch(0, 5, 0);
      en[0] = 1'b1;
      step(2);
      set_ch(0, 2, 0);
      step(3);
      check("t2_low_e4", clk_p[0], 1'b0);
      step(1);
      check("t2_old_period_e5", clk_p[0], 1'b1);
      step(1);
      check("t2_low_e6", clk_p[0], 1'b0);
      step(1);
      check("t2_new_period_e7", clk_p[0], 1'b1);
      step(2);
      check("t2_new_period_e9", clk_p[0], 1'b1);
      en[0] = 1'b0;
      step(2);

      // Prescaler 0 then 1: continuous high while enabled, low after disable.
      for (int p = 0; p < 2; p++) begin
         set_ch(0, p, 0);
         en[0] = 1'b1;
         step(2);
         check("t3_high_e1", clk_p[0], 1'b1);
         step(2);
         check("t3_high_e3", clk_p[0], 1'b1);
         en[0] = 1'b0;
         step(1);
         check("t3_low_after_drop", clk_p[0], 1'b0);
         check("t3_idle_after_drop", run[0], 1'b0);
         step(1);
      end

      // Two channels, period 8, phases 0 and 6, aligned by sync.
      set_ch(0, 8, 0);
      set_ch(1, 8, 6);
      en = 2'b11;
      step(3);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(2);
      check("t4_ch1_s2", clk_p[1], PhaseOn);
      step(6);
      check("t4_ch0_s8", clk_p[0], 1'b1);
      check("t4_ch1_s8", clk_p[1], !PhaseOn);
      step(2);
      check("t4_ch1_s10", clk_p[1], PhaseOn);
      en = '0;
      step(2);

      // Phase 9 with prescaler 4 clamps to 3.
      set_ch(1, 0, 0);
      set_ch(0, 4, 9);
      en[0] = 1'b1;
      step(2);
      check("t5_clamp_e1", clk_p[0], PhaseOn);
      step(3);
      check("t5_clamp_e4", clk_p[0], !PhaseOn);
      en[0] = 1'b0;
      step(2);

      // Sync on the terminal edge suppresses the pulse; disable on it too.
      set_ch(0, 4, 0);
      en[0] = 1'b1;
      step(4);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      check("t6_sync_suppress_e4", clk_p[0], 1'b0);
      check("t6_run_e4", run[0], 1'b1);
      step(4);
      check("t6_after_sync_e8", clk_p[0], 1'b1);
      step(3);
      en[0] = 1'b0;
      step(1);
      check("t6_drop_suppress_e12", clk_p[0], 1'b0);
      check("t6_drop_idle_e12", run[0], 1'b0);
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
